tsn_strict_priority_selector: RTL and testbench

- Transmission selection stage of the egress port. It takes NUM_QUEUES AXI4-Stream traffic-class queues, each already shaped by its own credit-based shaper, and merges them onto one egress stream.
- Selection is strict priority: the highest index is the highest priority.
- Queue eligibility is qualified by per-queue transmission gate state.
- Selection is made only on frame boundaries. Once granted, a frame is never interleaved with another.

---
 rtl/tsn_strict_priority_selector.sv | 114 +++++++++++
 tb/tb_tsn_strict_priority_selector.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsn_strict_priority_selector.sv
// Egress transmission selection: strict-priority merge of gate-qualified traffic-class
// queues onto one AXI4-Stream, arbitrating only on frame boundaries.
module tsn_strict_priority_selector #(
    parameter int unsigned NUM_QUEUES         = 4,
    parameter int unsigned C_AXIS_TDATA_WIDTH = 8,
    parameter int unsigned C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int unsigned FRAME_COUNT_WIDTH  = 16,
    parameter int unsigned QSEL_WIDTH         = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_QUEUES-1:0]                           transmission_gate_is_open,
    input  logic [NUM_QUEUES*C_AXIS_TDATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_TKEEP_WIDTH-1:0]        s_axis_tkeep,
    input  logic [NUM_QUEUES-1:0]                           s_axis_tvalid,
    output logic [NUM_QUEUES-1:0]                           s_axis_tready,
    input  logic [NUM_QUEUES-1:0]                           s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]                   m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0]                   m_axis_tkeep,
    output logic                                            m_axis_tvalid,
    input  logic                                            m_axis_tready,
    output logic                                            m_axis_tlast,
    output logic                                            busy,
    output logic [QSEL_WIDTH-1:0]                           selected_queue,
    output logic [NUM_QUEUES*FRAME_COUNT_WIDTH-1:0]         frame_count
);

    localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
    localparam int unsigned KW = C_AXIS_TKEEP_WIDTH;
    localparam int unsigned FW = FRAME_COUNT_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [QSEL_WIDTH-1:0] sel_q, sel_nxt;
    logic [FW-1:0]         cnt_q [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] eligible;
    logic                  sel_valid;
    logic                  xfer_done;

    assign eligible  = s_axis_tvalid & transmission_gate_is_open;
    assign xfer_done = (state == XFER) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Pass-through mux of the granted queue; no register in the data path
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tlast = 1'b0;
        sel_valid    = 1'b0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (sel_q == QSEL_WIDTH'(i)) begin
                m_axis_tdata = s_axis_tdata[i*DW +: DW];
                m_axis_tkeep = s_axis_tkeep[i*KW +: KW];
                m_axis_tlast = s_axis_tlast[i];
                sel_valid    = s_axis_tvalid[i];
            end
        end
    end

    assign m_axis_tvalid = (state == XFER) && sel_valid;

    // Only the granted queue sees downstream ready
    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            s_axis_tready[i] = (state == XFER) && (sel_q == QSEL_WIDTH'(i)) && m_axis_tready;
        end
    end

    // Next state: grant the highest eligible index, hold until the granted frame's last beat
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = XFER;
                    for (int i = 0; i < NUM_QUEUES; i++) begin
                        if (eligible[i]) sel_nxt = QSEL_WIDTH'(i);
                    end
                end
            end
            XFER: begin
                if (xfer_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= '0;
            for (int i = 0; i < NUM_QUEUES; i++) cnt_q[i] <= '0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (xfer_done && (sel_q == QSEL_WIDTH'(i))) cnt_q[i] <= cnt_q[i] + FW'(1);
            end
        end
    end

    assign busy           = (state == XFER);
    assign selected_queue = sel_q;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
        assign frame_count[g*FW +: FW] = cnt_q[g];
    end

endmodule

// File: tb/tb_tsn_strict_priority_selector.sv
// Scoreboard bench for tsn_strict_priority_selector: a frame-level priority model predicts
// the egress beat order; a negedge monitor checks every handshake and the ready routing.
module tb_tsn_strict_priority_selector;

    localparam int unsigned NQ  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned KW  = 1;
    localparam int unsigned FCW = 8;
    localparam int unsigned QW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NQ-1:0]     gate;
    logic [NQ*DW-1:0]  s_tdata;
    logic [NQ*KW-1:0]  s_tkeep;
    logic [NQ-1:0]     s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid, m_tready, m_tlast;
    logic              busy;
    logic [QW-1:0]     sel;
    logic [NQ*FCW-1:0] fcnt;

    tsn_strict_priority_selector #(
        .NUM_QUEUES(NQ), .C_AXIS_TDATA_WIDTH(DW), .C_AXIS_TKEEP_WIDTH(KW),
        .FRAME_COUNT_WIDTH(FCW), .QSEL_WIDTH(QW)
    ) dut (
        .clk(clk), .rst(rst), .transmission_gate_is_open(gate),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .busy(busy), .selected_queue(sel), .frame_count(fcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            q;
    } beat_t;

    beat_t src_q [NQ][$];
    beat_t mdl_q [NQ][$];
    beat_t exp_q [$];
    int    exp_cnt [NQ];
    bit    presented [NQ];
    bit    first_beat [NQ];
    bit    bubble_en;
    int    bp_pct;
    int    n_cmp, n_err;
    int    n_beats, cyc, last_end_cyc, last_gap;
    bit    prev_last, in_frame;
    logic [NQ-1:0] fire_s;
    logic          smp_mvalid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive per-queue sources; AXI valid is held until its handshake
    task automatic present();
        for (int i = 0; i < NQ; i++) begin
            if (!presented[i] && src_q[i].size() > 0) begin
                if (!(bubble_en && !first_beat[i] && $urandom_range(3) == 0)) presented[i] = 1'b1;
            end
            s_tvalid[i] = presented[i];
            if (presented[i]) begin
                s_tdata[i*DW +: DW] = src_q[i][0].data;
                s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                s_tlast[i]          = src_q[i][0].last;
            end else begin
                s_tdata[i*DW +: DW] = DW'($urandom);
                s_tkeep[i*KW +: KW] = KW'($urandom);
                s_tlast[i]          = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        beat_t b;
        @(negedge clk);
        fire_s     = s_tvalid & s_tready;
        smp_mvalid = m_tvalid;
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (fire_s[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                first_beat[i] = b.last;
                presented[i]  = 1'b0;
            end
        end
        m_tready = ($urandom_range(99) < bp_pct);
        present();
    endtask

    task automatic send(input int q, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = DW'($urandom);
            b.keep = KW'($urandom);
            b.last = (k == len - 1);
            b.q    = q;
            src_q[q].push_back(b);
            mdl_q[q].push_back(b);
        end
    endtask

    // Reference: with every pending head presented, whole frames leave highest open queue first
    task automatic schedule();
        int    hi;
        beat_t b;
        do begin
            hi = -1;
            for (int i = 0; i < NQ; i++) if (gate[i] && mdl_q[i].size() > 0) hi = i;
            if (hi >= 0) begin
                do begin
                    b = mdl_q[hi].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
                exp_cnt[hi] = (exp_cnt[hi] + 1) % (1 << FCW);
            end
        end while (hi >= 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
        tick();
        tick();
    endtask

    task automatic check_counts(input string name);
        for (int i = 0; i < NQ; i++) check(name, 32'(fcnt[i*FCW +: FCW]), 32'(exp_cnt[i]));
    endtask

    // Monitor: scoreboard pop on every egress handshake plus ready-routing checks
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (rst) begin
            prev_last = 1'b0;
            in_frame  = 1'b0;
        end else begin
            if (prev_last) check("busy_after_last", 32'(busy), 32'd0);
            if (!busy) check("mvalid_idle", 32'(m_tvalid), 32'd0);
            for (int i = 0; i < NQ; i++)
                check("s_tready_route", 32'(s_tready[i]),
                      32'((busy && sel == QW'(i)) ? m_tready : 1'b0));
            prev_last = 1'b0;
            if (m_tvalid && m_tready) begin
                n_beats++;
                if (!in_frame) last_gap = cyc - last_end_cyc;
                in_frame = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h from queue %0d expected none", m_tdata, sel);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(m_tdata), 32'(b.data));
                    check("beat_keep", 32'(m_tkeep), 32'(b.keep));
                    check("beat_last", 32'(m_tlast), 32'(b.last));
                    check("beat_queue", 32'(sel), 32'(b.q));
                end
                if (m_tlast) begin
                    prev_last    = 1'b1;
                    in_frame     = 1'b0;
                    last_end_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, k;
        rst = 1'b1; gate = '0; m_tready = 1'b1; bp_pct = 100; bubble_en = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        for (int i = 0; i < NQ; i++) begin
            presented[i] = 1'b0; first_beat[i] = 1'b1; exp_cnt[i] = 0;
        end
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_fcnt", fcnt, 32'd0);
        rst = 1'b0;
        tick();

        // Single 64-beat frame on queue 1
        gate = 4'b0010;
        send(1, 64); schedule(); present();
        n0 = n_beats;
        tick();
        check("latency_before", 32'(smp_mvalid), 32'd0);
        tick();
        check("latency_first", 32'(smp_mvalid), 32'd1);
        wait_idle("drain_single", 300);
        check("single_beats", 32'(n_beats - n0), 32'd64);
        check_counts("single_fcnt");

        // Priority: queue 3 before queue 0, one idle cycle between
        gate = 4'b1111;
        send(0, 5); send(3, 7); schedule(); present();
        wait_idle("drain_prio", 200);
        check("prio_gap", 32'(last_gap), 32'd2);
        check_counts("prio_fcnt");

        // Gate qualification and gate closing mid-frame
        gate = 4'b0010;
        send(3, 6); send(1, 12); schedule(); present();
        repeat (5) tick();
        gate[1] = 1'b0;
        wait_idle("drain_gate", 200);
        check_counts("gate_fcnt");
        gate[3] = 1'b1;
        schedule(); present();
        wait_idle("drain_gate_reopen", 200);
        check_counts("gate_reopen_fcnt");

        // No preemption by a later higher-priority arrival
        gate = 4'b1111;
        send(0, 16); schedule(); present();
        repeat (5) tick();
        send(2, 4); schedule(); present();
        wait_idle("drain_nopreempt", 200);
        check_counts("nopreempt_fcnt");

        // Randomized traffic with backpressure, source bubbles and random gates
        bubble_en = 1'b1; bp_pct = 60;
        for (int r = 0; r < 6; r++) begin
            gate = NQ'($urandom);
            for (int i = 0; i < NQ; i++) begin
                k = $urandom_range(2);
                for (int f = 0; f < k; f++) send(i, $urandom_range(12, 1));
            end
            schedule(); present();
            wait_idle("drain_rand", 3000);
            gate = 4'b1111;
            schedule(); present();
            wait_idle("drain_rand_open", 3000);
            check_counts("rand_fcnt");
        end
        bubble_en = 1'b0; bp_pct = 100;

        // Reset mid-frame at beat 10
        gate = 4'b0010;
        send(1, 20); schedule(); present();
        n0 = n_beats; k = 0;
        while (n_beats - n0 < 10 && k < 100) begin
            tick();
            k++;
        end
        check("rst_mid_reach", 32'(n_beats - n0), 32'd10);
        rst = 1'b1;
        tick();
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_s_tready", 32'(s_tready), 32'd0);
        check("rstmid_fcnt", fcnt, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            src_q[i].delete(); mdl_q[i].delete();
            presented[i] = 1'b0; first_beat[i] = 1'b1; exp_cnt[i] = 0;
        end
        exp_q.delete();
        present();
        tick();
        gate = 4'b0100;
        send(2, 5); schedule(); present();
        wait_idle("drain_after_rst", 100);
        check_counts("after_rst_fcnt");

        // Counter wrap on queue 2
        n0 = (1 << FCW) - 1 - exp_cnt[2];
        for (int f = 0; f < n0; f++) send(2, 1);
        schedule(); present();
        wait_idle("drain_preload", 4 * n0 + 50);
        check("wrap_pre", 32'(fcnt[2*FCW +: FCW]), 32'((1 << FCW) - 1));
        send(2, 3); schedule(); present();
        wait_idle("drain_wrap", 50);
        check("wrap_zero", 32'(fcnt[2*FCW +: FCW]), 32'd0);
        check_counts("wrap_fcnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
